mod_reduce_25519: RTL and testbench
===================================

MOD_REDUCE_25519 -- requirements
Module: mod_reduce_25519

Interface
REQ-001 SHALL have parameter PW, default 512, width of the unreduced product input.
REQ-002 SHALL have parameter FW, default 255, width of the reduced field-element output.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port product, input, PW, the unreduced 512-bit multiplier product.
REQ-006 SHALL have port in_valid, input, 1, meaning product is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1, meaning the block accepts product this cycle.
REQ-008 SHALL have port result, output, FW, equal to product mod p, where p = 2^255 - 19.
REQ-009 SHALL have port out_valid, output, 1, meaning result is valid.
REQ-010 SHALL have port out_ready, input, 1, meaning the consumer takes result this cycle.

Function
REQ-011 SHALL run an FSM with states IDLE, FOLD1, FOLD2, SUB and HOLD.
REQ-012 SHALL drive in_ready high only in IDLE.
REQ-013 SHALL accept in IDLE when in_valid and in_ready are both high, capture product into a PW-bit register, and go to FOLD1.
REQ-014 SHALL, in FOLD1, split the captured value as H = bits 511:255 (257 b) and L = bits 254:0, register s1 = L + 19*H (263 b, no overflow), and go to FOLD2.
REQ-015 SHALL, in FOLD2, split s1 as H2 = bits 262:255 (8 b) and L2 = bits 254:0, register s2 = L2 + 19*H2 (256 b), and go to SUB.
REQ-016 SHALL, in SUB, register result = (s2 >= p) ? s2 - p : s2, which needs one conditional subtract since s2 < 2p; it SHALL set out_valid and go to HOLD.
REQ-017 SHALL give fixed latency: out_valid rises exactly 4 cycles after the accepting edge.
REQ-018 SHALL, in HOLD, keep result and out_valid stable while out_ready is low, with no limit on stall length.
REQ-019 SHALL, in HOLD with out_ready high, clear out_valid at that edge and return to IDLE.
REQ-020 SHALL give throughput of at most one product per 5 cycles; in_valid outside IDLE is ignored and product is not sampled.
REQ-021 SHALL keep result unchanged from SUB until the next SUB, including while in IDLE.
REQ-022 SHALL produce a canonical result, always in 0..p-1, for every PW-bit input, including inputs at or above p and the input 2^512 - 1.

Reset
REQ-023 SHALL, while reset is high at a clock edge, set state to IDLE, out_valid to 0, result to 0 and all internal registers to 0.
REQ-024 SHALL, on reset in any state, discard any in-flight operation with no output for it; in_ready is 1 on the first cycle after reset deasserts.
REQ-025 SHALL ignore in_valid in a cycle where reset is high.

Structure
REQ-026 SHALL take P25519 (255-bit constant), the fold constant 19, the widths PW, FW, S1W = 263 and S2W = 256, and the FSM state enum from shared package mod25519_pkg.
REQ-027 SHALL implement REQ-014 and REQ-015 with one parameterized sub-module fold19 (inputs hi and lo, output lo + 19*hi), built as shift-add (hi<<4)+(hi<<1)+hi, instantiated twice.
REQ-028 SHALL contain no multi-cycle paths; each FSM state is one register stage.

Verification
REQ-029 SHALL cover: product = 0 -> result 0, out_valid 4 cycles after accept.
REQ-030 SHALL cover: product = 2^255 - 19 -> result 0; product = 2^255 - 20 -> result 2^255 - 20; product = 2^255 -> result 19.
REQ-031 SHALL cover: product = 2^512 - 1 -> result 1443; product = 2^256 - 38 (2p) -> result 0.
REQ-032 SHALL cover: out_ready held low 10 cycles in HOLD -> result and out_valid stable, in_ready low, new in_valid ignored; out_ready high -> IDLE next cycle.
REQ-033 SHALL cover: reset asserted in FOLD2 -> out_valid never rises for that product, result 0, in_ready 1 the cycle after reset drops.
REQ-034 SHALL cover: 1000 random 512-bit products back-to-back with random out_ready -> each result matches the reference model's product mod p, in order.

Source files
------------

// File: rtl/mod25519_pkg.sv
// Shared constants and FSM encoding for the
// 2^255-19 modular reduction datapath.
package mod25519_pkg;

   localparam int PW  = 512;
   localparam int FW  = 255;
   localparam int S1W = 263;
   localparam int S2W = 256;

   localparam int FOLD_K = 19;

   // 2^255 - 19: all ones except the low five bits 01101
   localparam logic [FW-1:0] P25519 = {{(FW-5){1'b1}}, 5'b01101};

   typedef enum logic [2:0] {
      IDLE,
      FOLD1,
      FOLD2,
      SUB,
      HOLD
   } state_t;

endpackage

// File: rtl/mod_reduce_25519_fold19.sv
// Folding step lo + 19*hi, using 2^255 == 19 (mod p),
// built from shifts and adds only.
module fold19 #(
   parameter int HW = 257,
   parameter int LW = 255,
   parameter int OW = 263
) (
   input  logic [HW-1:0] hi,
   input  logic [LW-1:0] lo,
   output logic [OW-1:0] sum
);

   logic [OW-1:0] h;
   logic [OW-1:0] l;

   assign h = OW'(hi);
   assign l = OW'(lo);

   // 19 = 16 + 2 + 1
   assign sum = l + (h << 4) + (h << 1) + h;

endmodule

// File: rtl/mod_reduce_25519.sv
// Reduces a 512-bit product modulo 2^255-19 in a
// fixed five-state pipeline with a held output.
module mod_reduce_25519 #(
   parameter int PW = mod25519_pkg::PW,
   parameter int FW = mod25519_pkg::FW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [PW-1:0] product,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [FW-1:0] result,
   output logic          out_valid,
   input  logic          out_ready
);

   import mod25519_pkg::*;

   localparam int HW  = PW - FW;
   localparam int H2W = S1W - FW;

   state_t         state;
   logic [PW-1:0]  prod_q;
   logic [S1W-1:0] s1;
   logic [S2W-1:0] s2;
   logic [S1W-1:0] f1;
   logic [S2W-1:0] f2;
   logic [FW-1:0]  diff;
   logic           ge;

   fold19 #(
      .HW(HW),
      .LW(FW),
      .OW(S1W)
   ) u_fold1 (
      .hi (prod_q[PW-1:FW]),
      .lo (prod_q[FW-1:0]),
      .sum(f1)
   );

   fold19 #(
      .HW(H2W),
      .LW(FW),
      .OW(S2W)
   ) u_fold2 (
      .hi (s1[S1W-1:FW]),
      .lo (s1[FW-1:0]),
      .sum(f2)
   );

   // s2 < 2p, so when s2 >= p the difference fits in FW bits
   assign ge   = s2 >= S2W'(P25519);
   assign diff = s2[FW-1:0] - P25519;

   assign in_ready = (state == IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         prod_q    <= '0;
         s1        <= '0;
         s2        <= '0;
         result    <= '0;
         out_valid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  prod_q <= product;
                  state  <= FOLD1;
               end
            end
            FOLD1: begin
               s1    <= f1;
               state <= FOLD2;
            end
            FOLD2: begin
               s2    <= f2;
               state <= SUB;
            end
            SUB: begin
               result    <= ge ? diff : s2[FW-1:0];
               out_valid <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mod_reduce_25519.sv
// Directed and random checks of mod_reduce_25519
// against an independent % based reference.
module tb_mod_reduce_25519;

   localparam int PW = 512;
   localparam int FW = 255;
   localparam logic [511:0] P_FULL = (512'd1 << 255) - 512'd19;

   logic          clk = 1'b0;
   logic          reset;
   logic [PW-1:0] product;
   logic          in_valid;
   logic          in_ready;
   logic [FW-1:0] result;
   logic          out_valid;
   logic          out_ready;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mod_reduce_25519 #(
      .PW(PW),
      .FW(FW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .product  (product),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .result   (result),
      .out_valid(out_valid),
      .out_ready(out_ready)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag,
                        input logic [511:0] obs,
                        input logic [511:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [511:0] rand512();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [254:0] ref_mod(input logic [511:0] x);
      logic [511:0] r;
      r = x % P_FULL;
      return r[254:0];
   endfunction

   task automatic run_vec(input string tag,
                          input logic [511:0] x,
                          input logic [254:0] exp);
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         step();
         n++;
      end
      product  = x;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 12) begin
         step();
         n++;
      end
      check({tag, "_lat"}, 512'(n), 512'd4);
      check({tag, "_res"}, 512'(result), 512'(exp));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({tag, "_idle"}, 512'({in_ready, out_valid}), 512'd2);
   endtask

   initial begin
      logic [511:0] x;
      logic [511:0] v;
      logic [254:0] e;
      int n;
      int seen;
      bit taken;

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      product   = '0;
      step();
      step();
      check("rst_valid", 512'(out_valid), 512'd0);
      check("rst_result", 512'(result), 512'd0);
      reset = 1'b0;
      step();
      check("rst_ready", 512'(in_ready), 512'd1);

      run_vec("zero", 512'd0, 255'd0);
      run_vec("p", P_FULL, 255'd0);
      run_vec("p_m1", P_FULL - 512'd1, 255'(P_FULL - 512'd1));
      run_vec("two255", 512'd1 << 255, 255'd19);
      v = '1;
      run_vec("all_ones", v, 255'd1443);
      run_vec("two_p", (512'd1 << 256) - 512'd38, 255'd0);
      run_vec("small", 512'd12345, 255'd12345);

      // stall in HOLD while a second request is offered
      product  = 512'd1 << 255;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 12) begin
         step();
         n++;
      end
      check("stall_lat", 512'(n), 512'd4);
      product  = 512'd777;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         check("stall_valid", 512'(out_valid), 512'd1);
         check("stall_res", 512'(result), 512'd19);
         check("stall_ready", 512'(in_ready), 512'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("stall_rel", 512'({in_ready, out_valid}), 512'd2);
      step();
      check("idle_keep", 512'(result), 512'd19);

      // reset during FOLD2 drops the product
      product  = P_FULL - 512'd1;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      check("mid_valid", 512'(out_valid), 512'd0);
      reset    = 1'b1;
      in_valid = 1'b1;
      product  = 512'd5;
      step();
      reset    = 1'b0;
      in_valid = 1'b0;
      check("mrst_ready", 512'(in_ready), 512'd1);
      check("mrst_result", 512'(result), 512'd0);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (out_valid) seen++;
         step();
      end
      check("mrst_quiet", 512'(seen), 512'd0);

      // back-to-back random traffic with random backpressure
      for (int i = 0; i < 1000; i++) begin
         x = rand512();
         if (i % 4 == 0) x[511:480] = '1;
         if (i % 7 == 0) x[511:255] = '0;
         product  = x;
         in_valid = 1'b1;
         n = 0;
         while (!in_ready && n < 20) begin
            step();
            n++;
         end
         step();
         e = ref_mod(x);
         product = rand512();
         n = 1;
         while (!out_valid && n < 12) begin
            step();
            n++;
         end
         check("rand_lat", 512'(n), 512'd4);
         check("rand_res", 512'(result), 512'(e));
         n = 0;
         taken = 1'b0;
         while (!taken && n < 60) begin
            out_ready = 1'($urandom_range(0, 1));
            taken = out_ready && out_valid;
            step();
            n++;
         end
         out_ready = 1'b0;
         if (!taken) check("rand_take", 512'(taken), 512'd1);
      end
      in_valid = 1'b0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
